// File: rtl/spi_thermo_pkg.sv
// -----------------------------------------------------------------------------
// spi_thermo_pkg
// Shared types and helpers for the thermometer level driver in the SPI
// execution unit.
//   thermo_state_t : controller state (idle / ramping toward a target)
//   sat_level      : clamps a requested level to the thermometer width
// -----------------------------------------------------------------------------
package spi_thermo_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RAMP
    } thermo_state_t;

    // Requests above the number of thermometer bits would address bits
    // that do not exist, so they are clamped to "all ones".
    function automatic int unsigned sat_level(input int unsigned level,
                                              input int unsigned max_level);
        return (level > max_level) ? max_level : level;
    endfunction

endpackage

// File: rtl/thermo_expand.sv
// -----------------------------------------------------------------------------
// thermo_expand
// Combinational binary-to-thermometer expander.
//   level  : binary level, 0..M
//   thermo : M-bit word with bits [level-1:0] set, all others clear
// -----------------------------------------------------------------------------
module thermo_expand #(
    parameter int M = 4,
    localparam int LW = $clog2(M + 1)
) (
    input  logic [LW-1:0] level,
    output logic [M-1:0]  thermo
);

    // Bit i is lit whenever the level is strictly above i.
    always_comb begin
        thermo = '0;
        for (int i = 0; i < M; i++) begin
            thermo[i] = (level > LW'(i));
        end
    end

endmodule

// File: rtl/thermo_level_ramp.sv
// -----------------------------------------------------------------------------
// thermo_level_ramp
// Registered, handshaked driver that turns a binary level command into an
// M-bit thermometer word. With RAMP=0 the level jumps straight to the target;
// with RAMP=1 it slews one level per cycle so the enable vector never changes
// by more than one bit at a time. o_done pulses for one cycle on arrival.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_valid   : command valid, taken when o_ready is high
//   o_ready   : command can be accepted this cycle
//   i_level   : target level, values above M saturate to M
//   o_thermo  : registered thermometer word matching o_level
//   o_level   : current level, binary
//   o_done    : one-cycle pulse when the target is reached
//   o_busy    : ramp in progress
// -----------------------------------------------------------------------------
module thermo_level_ramp
    import spi_thermo_pkg::*;
#(
    parameter int M = 4,
    parameter bit RAMP = 1'b0,
    localparam int LW = $clog2(M + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [LW-1:0] i_level,
    output logic [M-1:0]  o_thermo,
    output logic [LW-1:0] o_level,
    output logic          o_done,
    output logic          o_busy
);

    thermo_state_t state, state_nxt;
    logic [LW-1:0] level, level_nxt;
    logic [LW-1:0] target, target_nxt;
    logic [LW-1:0] cmd_level;
    logic [LW-1:0] first_step;
    logic [M-1:0]  thermo_q, thermo_nxt;
    logic          done_q, done_nxt;
    logic          ready_q, busy_q;
    logic          accept;

    function automatic logic [LW-1:0] step_toward(input logic [LW-1:0] from,
                                                  input logic [LW-1:0] to);
        return (to > from) ? from + 1'b1 : from - 1'b1;
    endfunction

    assign accept     = i_valid && ready_q;
    assign cmd_level  = LW'(sat_level(32'(i_level), M));
    assign first_step = step_toward(level, cmd_level);

    // Next-state logic. In idle a command either lands immediately (jump
    // mode, zero distance, or a single step) or starts a ramp; in ramp the
    // level walks one step per cycle and the arriving edge returns to idle
    // and raises done.
    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        target_nxt = target;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    target_nxt = cmd_level;
                    if (!RAMP || (cmd_level == level)) begin
                        level_nxt = cmd_level;
                        done_nxt  = 1'b1;
                    end else begin
                        level_nxt = first_step;
                        if (first_step == cmd_level) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_RAMP;
                        end
                    end
                end
            end
            ST_RAMP: begin
                level_nxt = step_toward(level, target);
                if (level_nxt == target) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The thermometer is expanded from the next level so that it is
    // registered in the same edge as o_level and the two can never disagree.
    thermo_expand #(
        .M(M)
    ) u_expand (
        .level  (level_nxt),
        .thermo (thermo_nxt)
    );

    // State, level, target and handshake flags. Ready and busy are
    // registered from the next state, so ready is low throughout reset and
    // rises on the first edge after reset is released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            level    <= '0;
            target   <= '0;
            thermo_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            target   <= target_nxt;
            thermo_q <= thermo_nxt;
            done_q   <= done_nxt;
            ready_q  <= (state_nxt == ST_IDLE);
            busy_q   <= (state_nxt == ST_RAMP);
        end
    end

    assign o_ready  = ready_q;
    assign o_busy   = busy_q;
    assign o_level  = level;
    assign o_thermo = thermo_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_thermo_level_ramp.sv
// -----------------------------------------------------------------------------
// tb_thermo_level_ramp
// Drives a jump-mode (RAMP=0) and a slew-mode (RAMP=1) instance, M=4, from a
// shared clock and reset. A directed table covers the reset, jump, ramp,
// saturation and mid-ramp-reset sequences; a random phase follows. Every
// cycle is also compared against a plan-based reference model.
// -----------------------------------------------------------------------------
module tb_thermo_level_ramp;

    localparam int M  = 4;
    localparam int LW = $clog2(M + 1);

    logic          clk;
    logic          rst;
    logic          valid0, valid1;
    logic [LW-1:0] level_in0, level_in1;
    logic          ready0, ready1;
    logic [M-1:0]  thermo0, thermo1;
    logic [LW-1:0] level_out0, level_out1;
    logic          done0, done1;
    logic          busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    thermo_level_ramp #(.M(M), .RAMP(1'b0)) dut_jump (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid0),
        .o_ready  (ready0),
        .i_level  (level_in0),
        .o_thermo (thermo0),
        .o_level  (level_out0),
        .o_done   (done0),
        .o_busy   (busy0)
    );

    thermo_level_ramp #(.M(M), .RAMP(1'b1)) dut_ramp (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid1),
        .o_ready  (ready1),
        .i_level  (level_in1),
        .o_thermo (thermo1),
        .o_level  (level_out1),
        .o_done   (done1),
        .o_busy   (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: an accepted command is turned into the list of levels
    // the output will show on the following edges; each edge consumes one.
    int plan [2][8];
    int plen [2];
    int ppos [2];
    int mlvl [2];
    bit mdone[2];
    bit mrdy [2];

    task automatic modelEdge(input int k, input bit r, input bit v, input int l);
        int t;
        int x;
        if (r) begin
            plen[k] = 0; ppos[k] = 0; mlvl[k] = 0; mdone[k] = 1'b0; mrdy[k] = 1'b0;
            return;
        end
        if (mrdy[k] && v) begin
            t = (l > M) ? M : l;
            plen[k] = 0;
            ppos[k] = 0;
            if (k == 0 || t == mlvl[k]) begin
                plan[k][0] = t;
                plen[k] = 1;
            end else begin
                x = mlvl[k];
                while (x != t) begin
                    x = (t > x) ? x + 1 : x - 1;
                    plan[k][plen[k]] = x;
                    plen[k]++;
                end
            end
        end
        if (ppos[k] < plen[k]) begin
            mlvl[k] = plan[k][ppos[k]];
            ppos[k]++;
            mdone[k] = (ppos[k] == plen[k]);
        end else begin
            mdone[k] = 1'b0;
        end
        mrdy[k] = (ppos[k] == plen[k]);
    endtask

    function automatic logic [M-1:0] thermoOf(input int l);
        return M'((1 << l) - 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("jump.thermo", 32'(thermo0),    32'(thermoOf(mlvl[0])));
        checkOutput("jump.level",  32'(level_out0), 32'(mlvl[0]));
        checkOutput("jump.done",   32'(done0),      32'(mdone[0]));
        checkOutput("jump.ready",  32'(ready0),     32'(mrdy[0]));
        checkOutput("jump.busy",   32'(busy0),      32'(ppos[0] < plen[0]));
        checkOutput("ramp.thermo", 32'(thermo1),    32'(thermoOf(mlvl[1])));
        checkOutput("ramp.level",  32'(level_out1), 32'(mlvl[1]));
        checkOutput("ramp.done",   32'(done1),      32'(mdone[1]));
        checkOutput("ramp.ready",  32'(ready1),     32'(mrdy[1]));
        checkOutput("ramp.busy",   32'(busy1),      32'(ppos[1] < plen[1]));
    endtask

    // One clock: drive inputs, advance the model, then sample on the
    // falling edge after the rising edge.
    task automatic applyStimulus(input bit r, input bit v0, input int l0,
                                 input bit v1, input int l1);
        rst       = r;
        valid0    = v0;
        level_in0 = LW'(l0);
        valid1    = v1;
        level_in1 = LW'(l1);
        modelEdge(0, r, v0, l0);
        modelEdge(1, r, v1, l1);
        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    typedef struct {
        bit           rst;
        bit           v0;
        int           l0;
        bit           v1;
        int           l1;
        logic [M-1:0] t0;
        bit           d0;
        logic [M-1:0] t1;
        bit           d1;
        bit           r1;
    } vec_t;

    function automatic vec_t mk(input int r, input int v0, input int l0, input int v1,
                                input int l1, input int t0, input int d0, input int t1,
                                input int d1, input int r1);
        vec_t x;
        x.rst = bit'(r);  x.v0 = bit'(v0); x.l0 = l0; x.v1 = bit'(v1); x.l1 = l1;
        x.t0 = M'(t0);    x.d0 = bit'(d0); x.t1 = M'(t1); x.d1 = bit'(d1); x.r1 = bit'(r1);
        return x;
    endfunction

    vec_t vecs[25];

    initial begin
        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; level_in0 = '0; level_in1 = '0;
        foreach (mlvl[k]) begin
            plen[k] = 0; ppos[k] = 0; mlvl[k] = 0; mdone[k] = 1'b0; mrdy[k] = 1'b0;
        end

        //             rst v0 l0 v1 l1  thermo0  d0  thermo1  d1 r1
        vecs[0]  = mk(1, 1, 3, 1, 3, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[1]  = mk(1, 1, 3, 1, 3, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[2]  = mk(0, 1, 3, 1, 3, 4'b0000, 0, 4'b0000, 0, 1);
        vecs[3]  = mk(0, 1, 3, 1, 4, 4'b0111, 1, 4'b0001, 0, 0);
        vecs[4]  = mk(0, 1, 1, 1, 2, 4'b0001, 1, 4'b0011, 0, 0);
        vecs[5]  = mk(0, 1, 4, 1, 0, 4'b1111, 1, 4'b0111, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 4'b1111, 0, 4'b1111, 1, 1);
        vecs[7]  = mk(0, 1, 7, 1, 1, 4'b1111, 1, 4'b0111, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 4'b0000, 1, 4'b0011, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 1, 1);
        vecs[10] = mk(0, 1, 2, 1, 1, 4'b0011, 1, 4'b0001, 1, 1);
        vecs[11] = mk(0, 0, 0, 1, 2, 4'b0011, 0, 4'b0011, 1, 1);
        vecs[12] = mk(0, 0, 0, 1, 7, 4'b0011, 0, 4'b0111, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 4'b0011, 0, 4'b1111, 1, 1);
        vecs[14] = mk(0, 0, 0, 1, 0, 4'b0011, 0, 4'b0111, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 4'b0011, 0, 4'b0011, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 4'b0011, 0, 4'b0001, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 4'b0011, 0, 4'b0000, 1, 1);
        vecs[18] = mk(0, 0, 0, 1, 4, 4'b0011, 0, 4'b0001, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 4'b0011, 0, 4'b0011, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 1);
        vecs[22] = mk(0, 0, 0, 1, 2, 4'b0000, 0, 4'b0001, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0011, 1, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0011, 0, 1);

        $display("[TB] directed vectors");
        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].v0, vecs[i].l0, vecs[i].v1, vecs[i].l1);
            checkOutput($sformatf("vec%0d.jump.thermo", i), 32'(thermo0), 32'(vecs[i].t0));
            checkOutput($sformatf("vec%0d.jump.done", i),   32'(done0),   32'(vecs[i].d0));
            checkOutput($sformatf("vec%0d.ramp.thermo", i), 32'(thermo1), 32'(vecs[i].t1));
            checkOutput($sformatf("vec%0d.ramp.done", i),   32'(done1),   32'(vecs[i].d1));
            checkOutput($sformatf("vec%0d.ramp.ready", i),  32'(ready1),  32'(vecs[i].r1));
        end

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
